// File: rtl/painterengine_gpu_blender.sv
// Pixel-combine stage of the GPU render path.
// Pops one source pixel (FIFO1) and one destination pixel (FIFO2) per pixel of a block,
// combines them (copy or source-over alpha blend) and pushes the result to the writer FIFO.
// Two register stages: S1 holds per-channel products, S2 holds the normalised pixel.
//
// Ports:
//   i_wire_clock        system clock (rising edge)
//   i_wire_reset        synchronous active-high reset
//   i_wire_start        start pulse, accepted only in IDLE or DONE
//   i_wire_length       block pixel count (low COUNT_WIDTH bits used)
//   i_wire_blend_mode   0 = copy source, 1 = source-over blend
//   i_wire_fifo1_*      source FIFO (FWFT): empty, data, rd_en
//   i_wire_fifo2_*      destination FIFO (FWFT): empty, data, rd_en
//   i_wire_out_full     writer FIFO full
//   o_wire_out_wr_en    push strobe for o_wire_out_data
//   o_wire_done         level, high while in DONE
//   o_wire_state        {30'd0, state}
module painterengine_gpu_blender #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_start,
  input  logic [31:0] i_wire_length,
  input  logic        i_wire_blend_mode,
  input  logic        i_wire_fifo1_empty,
  input  logic [31:0] i_wire_fifo1_data,
  output logic        o_wire_fifo1_rd_en,
  input  logic        i_wire_fifo2_empty,
  input  logic [31:0] i_wire_fifo2_data,
  output logic        o_wire_fifo2_rd_en,
  input  logic        i_wire_out_full,
  output logic        o_wire_out_wr_en,
  output logic [31:0] o_wire_out_data,
  output logic        o_wire_done,
  output logic [31:0] o_wire_state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] length_q, length_d;
  logic                   mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
  logic [COUNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;

  logic        s1_valid_q;
  logic [31:0] s1_src_q;
  logic [15:0] s1_t_a_q, s1_t_r_q, s1_t_g_q, s1_t_b_q;
  logic        s2_valid_q;
  logic [31:0] s2_data_q;

  logic        s1_adv, s2_adv, pop, wr;
  logic [7:0]  sa, na;
  logic [15:0] t_a, t_r, t_g, t_b;
  logic [8:0]  alpha_sum;
  logic [31:0] s2_data_d;
  logic [COUNT_WIDTH-1:0] start_len;

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    return {8'd0, a} * {8'd0, b};
  endfunction

  // Exact round(t/255) for t <= 65025; the 17-bit sum never exceeds 65407.
  function automatic logic [7:0] norm255(input logic [15:0] t);
    logic [16:0] r;
    logic [16:0] s;
    r = {1'b0, t} + 17'd128;
    s = r + (r >> 8);
    return s[15:8];
  endfunction

  generate
    if (COUNT_WIDTH < 32) begin : g_len_unused
      logic unused_len_hi;
      assign unused_len_hi = ^i_wire_length[31:COUNT_WIDTH];
    end
  endgenerate

  assign start_len = i_wire_length[COUNT_WIDTH-1:0];

  // Handshake. Reset gates the strobes so an abandoned block leaves the FIFOs untouched.
  always_comb begin
    s2_adv = !s2_valid_q || !i_wire_out_full;
    s1_adv = !s1_valid_q || s2_adv;
    pop    = (state_q == StRun) && (pop_cnt_q < length_q) && !i_wire_fifo1_empty &&
             !i_wire_fifo2_empty && s1_adv && !i_wire_reset;
    wr     = s2_valid_q && !i_wire_out_full && !i_wire_reset;
  end

  assign o_wire_fifo1_rd_en = pop;
  assign o_wire_fifo2_rd_en = pop;
  assign o_wire_out_wr_en   = wr;
  assign o_wire_out_data    = s2_data_q;
  assign o_wire_done        = (state_q == StDone);
  assign o_wire_state       = {30'd0, state_q};

  // S1 product terms.
  always_comb begin
    sa  = i_wire_fifo1_data[31:24];
    na  = 8'd255 - sa;
    t_a = mul8(i_wire_fifo2_data[31:24], na);
    t_r = mul8(i_wire_fifo1_data[23:16], sa) + mul8(i_wire_fifo2_data[23:16], na);
    t_g = mul8(i_wire_fifo1_data[15:8], sa) + mul8(i_wire_fifo2_data[15:8], na);
    t_b = mul8(i_wire_fifo1_data[7:0], sa) + mul8(i_wire_fifo2_data[7:0], na);
  end

  // S2 normalisation.
  always_comb begin
    alpha_sum = {1'b0, s1_src_q[31:24]} + {1'b0, norm255(s1_t_a_q)};
    s2_data_d = s1_src_q;
    if (mode_q) begin
      s2_data_d = {(alpha_sum[8] ? 8'hFF : alpha_sum[7:0]),
                   norm255(s1_t_r_q), norm255(s1_t_g_q), norm255(s1_t_b_q)};
    end
  end

  // Block control.
  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    mode_d    = mode_q;
    pop_cnt_d = pop ? pop_cnt_q + CntOne : pop_cnt_q;
    wr_cnt_d  = wr ? wr_cnt_q + CntOne : wr_cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_wire_start) begin
          length_d  = start_len;
          mode_d    = i_wire_blend_mode;
          pop_cnt_d = '0;
          wr_cnt_d  = '0;
          state_d   = (start_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (pop_cnt_q == length_q) state_d = StDrain;
      end
      StDrain: begin
        if (wr_cnt_q == length_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q    <= StIdle;
      length_q   <= '0;
      mode_q     <= 1'b0;
      pop_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_src_q   <= '0;
      s1_t_a_q   <= '0;
      s1_t_r_q   <= '0;
      s1_t_g_q   <= '0;
      s1_t_b_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      mode_q    <= mode_d;
      pop_cnt_q <= pop_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      if (s1_adv) begin
        s1_valid_q <= pop;
        if (pop) begin
          s1_src_q <= i_wire_fifo1_data;
          s1_t_a_q <= t_a;
          s1_t_r_q <= t_r;
          s1_t_g_q <= t_g;
          s1_t_b_q <= t_b;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        // Data only moves when a valid pixel arrives, so it holds while stalled.
        if (s1_valid_q) s2_data_q <= s2_data_d;
      end
    end
  end

endmodule
